// File: rtl/exc_ctrl_pkg.sv
// rtl/exc_ctrl_pkg.sv - ExcCodes, CP0 field positions, vector constants and FSM states
package exc_ctrl_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_TLBM = 5'h01;
    localparam logic [4:0] EXC_TLBL = 5'h02;
    localparam logic [4:0] EXC_TLBS = 5'h03;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_CPU  = 5'h0B;
    localparam logic [4:0] EXC_OV   = 5'h0C;
    localparam logic [4:0] EXC_TR   = 5'h0D;
    localparam logic [4:0] EXC_ERET = 5'h1F;

    localparam int SR_IE    = 0;
    localparam int SR_EXL   = 1;
    localparam int SR_ERL   = 2;
    localparam int SR_IM_LO = 8;
    localparam int SR_BEV   = 22;
    localparam int CA_IP_LO = 8;

    localparam logic [31:0] VEC_BASE_BOOT  = 32'hBFC0_0200;
    localparam logic [31:0] VEC_BASE_NORM  = 32'h8000_0000;
    localparam logic [31:0] VEC_OFF_REFILL = 32'h0000_0000;
    localparam logic [31:0] VEC_OFF_GEN    = 32'h0000_0180;

    // Source 19 first (MSB) down to source 0; lower index wins.
    localparam logic [99:0] EXC_CODE_TBL_DEF = {
        EXC_ERET, EXC_RI,   EXC_RI,   EXC_TLBM, EXC_TLBS,
        EXC_TLBL, EXC_TLBS, EXC_TLBL, EXC_ADES, EXC_ADEL,
        EXC_TR,   EXC_OV,   EXC_BP,   EXC_SYS,  EXC_CPU,
        EXC_RI,   EXC_TLBL, EXC_TLBL, EXC_ADEL, EXC_INT
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_REDIRECT
    } exc_state_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// rtl/exc_ctrl_if.sv - commit-stage exception inputs and flush/redirect handshake
interface exc_ctrl_if #(
    parameter int EXC_W  = 20,
    parameter int ADDR_W = 32
);
    logic              inst_valid;
    logic [EXC_W-1:0]  excp_i;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] m_vaddr;
    logic              in_delay;
    logic              d_refs;
    logic              flush_ack;
    logic              flush_req;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output inst_valid, excp_i, pc, m_vaddr, in_delay, d_refs, flush_ack,
        input  flush_req, redirect_valid, redirect_pc
    );

    modport slave (
        input  inst_valid, excp_i, pc, m_vaddr, in_delay, d_refs, flush_ack,
        output flush_req, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/exc_ctrl_int_sync.sv
// rtl/exc_ctrl_int_sync.sv - per-line flop chain synchroniser for hardware interrupts
module exc_ctrl_int_sync #(
    parameter int N      = 6,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] async_in,
    output logic [N-1:0] sync_out
);
    localparam int S = (STAGES < 1) ? 1 : STAGES;

    logic [S-1:0][N-1:0] stage;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage[0] <= async_in;
            for (int i = 1; i < S; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign sync_out = stage[S-1];
endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - commit-stage exception prioritiser with registered CP0 update and flush/redirect sequence
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter int                  EXC_W           = 20,
    parameter int                  NUM_HW_INT      = 6,
    parameter int                  INT_SYNC_STAGES = 2,
    parameter int                  ADDR_W          = 32,
    parameter logic [EXC_W*5-1:0]  EXC_CODE_TBL    = EXC_CODE_TBL_DEF,
    parameter logic [EXC_W-1:0]    BADDR_PC_MASK   = '0,
    parameter logic [EXC_W-1:0]    BADDR_DATA_MASK = '0,
    parameter logic [EXC_W-1:0]    REFILL_MASK     = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    exc_ctrl_if.slave             pipe,
    input  logic [NUM_HW_INT-1:0] hw_int,
    input  logic [31:0]           cp0_Status,
    input  logic [31:0]           cp0_Cause,
    input  logic [ADDR_W-1:0]     cp0_EPC,
    output logic [NUM_HW_INT-1:0] int_pending,
    output logic                  exc_flag,
    output logic [4:0]            exc_type,
    output logic                  exc_bd,
    output logic [ADDR_W-1:0]     exc_epc,
    output logic [ADDR_W-1:0]     exc_baddr,
    output logic                  exc_save
);
    localparam int WIN_W = (EXC_W > 1) ? $clog2(EXC_W) : 1;

    exc_state_t        state, state_nx;
    logic              intr, hit, detect, is_eret;
    logic [EXC_W-1:0]  eff;
    logic [WIN_W-1:0]  win;
    logic [4:0]        code;
    logic [31:0]       vec_base, vec_off;
    logic [ADDR_W-1:0] vec;
    logic              unused_bits;

    exc_ctrl_int_sync #(.N(NUM_HW_INT), .STAGES(INT_SYNC_STAGES)) u_int_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (hw_int),
        .sync_out (int_pending)
    );

    assign intr = (|(cp0_Cause[CA_IP_LO +: 8] & cp0_Status[SR_IM_LO +: 8]))
                  && cp0_Status[SR_IE] && !cp0_Status[SR_EXL] && !cp0_Status[SR_ERL];
    assign eff  = {pipe.excp_i[EXC_W-1:1], intr};

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        hit = 1'b0;
        win = '0;
        for (int i = EXC_W - 1; i >= 0; i--) begin
            if (eff[i]) begin
                hit = 1'b1;
                win = WIN_W'(i);
            end
        end
    end

    assign is_eret  = (int'(win) == EXC_W - 1);
    assign code     = EXC_CODE_TBL[int'(win)*5 +: 5];
    assign vec_base = cp0_Status[SR_BEV] ? VEC_BASE_BOOT : VEC_BASE_NORM;
    assign vec_off  = (REFILL_MASK[win] && !cp0_Status[SR_EXL]) ? VEC_OFF_REFILL : VEC_OFF_GEN;
    assign vec      = ADDR_W'(vec_base + vec_off);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        detect   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pipe.inst_valid && hit) begin
                    detect   = 1'b1;
                    state_nx = ST_FLUSH;
                end
            end
            ST_FLUSH:    if (pipe.flush_ack) state_nx = ST_REDIRECT;
            ST_REDIRECT: state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_flag            <= 1'b0;
            exc_type            <= '0;
            exc_bd              <= 1'b0;
            exc_epc             <= '0;
            exc_baddr           <= '0;
            exc_save            <= 1'b0;
            pipe.flush_req      <= 1'b0;
            pipe.redirect_valid <= 1'b0;
            pipe.redirect_pc    <= '0;
        end else begin
            exc_flag            <= 1'b0;
            pipe.redirect_valid <= 1'b0;
            if (detect) begin
                exc_type         <= code;
                pipe.flush_req   <= 1'b1;
                pipe.redirect_pc <= is_eret ? cp0_EPC : vec;
                // ERET only reports its code; CP0 state is left untouched.
                if (!is_eret) begin
                    exc_flag <= 1'b1;
                    exc_bd   <= pipe.in_delay;
                    exc_epc  <= pipe.in_delay ? pipe.pc - ADDR_W'(4) : pipe.pc;
                    if (BADDR_PC_MASK[win]) begin
                        exc_baddr <= pipe.pc;
                        exc_save  <= 1'b0;
                    end else begin
                        exc_baddr <= BADDR_DATA_MASK[win] ? pipe.m_vaddr : '0;
                        exc_save  <= pipe.d_refs;
                    end
                end
            end
            if (state == ST_FLUSH && pipe.flush_ack) begin
                pipe.flush_req      <= 1'b0;
                pipe.redirect_valid <= 1'b1;
            end
        end
    end

    assign unused_bits = ^{cp0_Status[31:23], cp0_Status[21:16], cp0_Status[7:3],
                           cp0_Cause[31:16], cp0_Cause[7:0], pipe.excp_i[0]};
endmodule
